// File: rtl/layer_sequencer.sv
// layer_sequencer: steps one frame through the conv/pool/fc/judge layers, issuing start pulses and per-layer configuration.
module layer_sequencer #(
  parameter int ADDRESS_DATAWIDTH = 13,
  parameter int STATE_DATAWIDTH = 4,
  parameter int INPUT_SIZE = 80,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_DATAWIDTH-1:0] address,
  input  logic                         conv_done,
  input  logic                         avg_done,
  input  logic                         fc_done,
  input  logic                         judge_done,
  input  logic                         abort,
  output logic [STATE_DATAWIDTH-1:0]   state,
  output logic                         conv_start,
  output logic                         avg_start,
  output logic                         fc_start,
  output logic                         judge_start,
  output logic [6:0]                   fmap_size,
  output logic [4:0]                   cin,
  output logic [4:0]                   cout,
  output logic [12:0]                  wbase,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err
);
  typedef enum logic [3:0] {
    IDLE, CONV1_1, CONV1_2, AVG_POOL1, CONV2_1, CONV2_2, AVG_POOL2,
    CONV3_1, CONV3_2, AVG_POOL3, FC, JUDGE
  } state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDRESS_DATAWIDTH-1:0] LAST = ADDRESS_DATAWIDTH'(INPUT_SIZE * INPUT_SIZE - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic armed_q, armed_d, frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] start_q, start_d;
  logic [29:0] cfg_q, cfg_d;
  logic is_avg, done_exp, tmo, entering;
  always_comb begin
    is_avg = state_q inside {AVG_POOL1, AVG_POOL2, AVG_POOL3};
    // the start-pulse cycle never accepts a done
    done_exp = (start_q == 4'd0) && (state_q == FC ? fc_done : state_q == JUDGE ? judge_done :
               is_avg ? avg_done : conv_done);
    tmo = cnt_q == TMAX;
    state_d = state_q;
    if (state_q == IDLE) state_d = (armed_q && address != LAST && !abort) ? CONV1_1 : IDLE;
    else if (abort) state_d = IDLE;
    else if (done_exp) state_d = state_q == JUDGE ? IDLE : state_t'(state_q + 4'd1);
    else if (tmo) state_d = IDLE;
    armed_d = state_q == IDLE && state_d == IDLE && !abort && (armed_q || address == LAST);
    frame_done_d = state_q == JUDGE && !abort && done_exp;
    timeout_err_d = timeout_err_q || (state_q != IDLE && !abort && !done_exp && tmo);
    entering = state_d != state_q && state_d != IDLE;
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    start_d = !entering ? 4'b0000 : state_d == FC ? 4'b0010 : state_d == JUDGE ? 4'b0001 :
              state_d inside {AVG_POOL1, AVG_POOL2, AVG_POOL3} ? 4'b0100 : 4'b1000;
    case (state_d)
      CONV1_1:   cfg_d = {7'd80, 5'd1,  5'd4,  13'd0};
      CONV1_2:   cfg_d = {7'd80, 5'd4,  5'd4,  13'd36};
      AVG_POOL1: cfg_d = {7'd80, 5'd4,  5'd4,  13'd0};
      CONV2_1:   cfg_d = {7'd40, 5'd4,  5'd8,  13'd180};
      CONV2_2:   cfg_d = {7'd40, 5'd8,  5'd8,  13'd468};
      AVG_POOL2: cfg_d = {7'd40, 5'd8,  5'd8,  13'd0};
      CONV3_1:   cfg_d = {7'd20, 5'd8,  5'd16, 13'd1044};
      CONV3_2:   cfg_d = {7'd20, 5'd16, 5'd16, 13'd2196};
      AVG_POOL3: cfg_d = {7'd20, 5'd16, 5'd16, 13'd0};
      FC:        cfg_d = {7'd10, 5'd16, 5'd2,  13'd4500};
      JUDGE:     cfg_d = {7'd0,  5'd2,  5'd2,  13'd0};
      default:   cfg_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q <= '0;
      start_q <= '0;
      cfg_q <= '0;
      frame_done_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      cfg_q <= cfg_d;
      frame_done_q <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign state = STATE_DATAWIDTH'(state_q);
  assign {conv_start, avg_start, fc_start, judge_start} = start_q;
  assign {fmap_size, cin, cout, wbase} = cfg_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench; each layer entry is predicted when its trigger is driven and checked at the start pulse.
module tb_layer_sequencer;
  logic clk = 1'b0, reset = 1'b0;
  logic [12:0] address = '0;
  logic conv_done = 0, avg_done = 0, fc_done = 0, judge_done = 0, abort = 0;
  logic [3:0] state;
  logic conv_start, avg_start, fc_start, judge_start;
  logic [6:0] fmap_size;
  logic [4:0] cin, cout;
  logic [12:0] wbase;
  logic busy, frame_done, timeout_err;
  int total = 0, bad = 0;
  typedef struct {int st; logic [3:0] strt; int fm; int ci; int co; int wb;} exp_t;
  exp_t sb[$];

  layer_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .address(address), .conv_done(conv_done), .avg_done(avg_done),
    .fc_done(fc_done), .judge_done(judge_done), .abort(abort), .state(state),
    .conv_start(conv_start), .avg_start(avg_start), .fc_start(fc_start), .judge_start(judge_start),
    .fmap_size(fmap_size), .cin(cin), .cout(cout), .wbase(wbase), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  function automatic exp_t model(input int s);
    exp_t e;
    e.st = s;
    case (s)
      1: e = '{1, 4'b1000, 80, 1, 4, 0};
      2: e = '{2, 4'b1000, 80, 4, 4, 36};
      3: e = '{3, 4'b0100, 80, 4, 4, 0};
      4: e = '{4, 4'b1000, 40, 4, 8, 180};
      5: e = '{5, 4'b1000, 40, 8, 8, 468};
      6: e = '{6, 4'b0100, 40, 8, 8, 0};
      7: e = '{7, 4'b1000, 20, 8, 16, 1044};
      8: e = '{8, 4'b1000, 20, 16, 16, 2196};
      9: e = '{9, 4'b0100, 20, 16, 16, 0};
      10: e = '{10, 4'b0010, 10, 16, 2, 4500};
      default: e = '{11, 4'b0001, 0, 2, 2, 0};
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (busy !== (state != 4'd0)) begin
        bad++;
        $display("FAIL busy_track: busy=%b state=%0d", busy, state);
      end
      if ({conv_start, avg_start, fc_start, judge_start} != 4'b0000) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_start: starts=%b state=%0d, none expected", {conv_start, avg_start, fc_start, judge_start}, state);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (state !== 4'(e.st) || {conv_start, avg_start, fc_start, judge_start} !== e.strt ||
              fmap_size !== 7'(e.fm) || cin !== 5'(e.ci) || cout !== 5'(e.co) || wbase !== 13'(e.wb)) begin
            bad++;
            $display("FAIL layer_entry: got st=%0d starts=%b cfg=%0d/%0d/%0d/%0d want st=%0d starts=%b cfg=%0d/%0d/%0d/%0d",
              state, {conv_start, avg_start, fc_start, judge_start}, fmap_size, cin, cout, wbase,
              e.st, e.strt, e.fm, e.ci, e.co, e.wb);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    address = 13'd1;
    step();
    address = 13'd6399;
    step();
    address = 13'd1;
    sb.push_back(model(1));
    step();
  endtask

  task automatic drive_done(input int s, input logic v);
    if (s == 10) fc_done = v;
    else if (s == 11) judge_done = v;
    else if (s == 3 || s == 6 || s == 9) avg_done = v;
    else conv_done = v;
  endtask

  task automatic run_layer(input int s, input bit wrong);
    @(negedge clk);
    total++;
    if (state !== 4'(s)) begin
      bad++;
      $display("FAIL layer_state: state=%0d want %0d", state, s);
    end
    if (wrong && s == 2) begin
      conv_done = 1;
      step();
      conv_done = 0;
      @(negedge clk);
      total++;
      if (state !== 4'd2) begin
        bad++;
        $display("FAIL done_in_start_cycle: state=%0d want 2", state);
      end
    end else step();
    step();
    if (wrong && (s == 1 || s == 10)) begin
      if (s == 1) avg_done = 1; else conv_done = 1;
      step();
      avg_done = 0;
      conv_done = 0;
      @(negedge clk);
      total++;
      if (state !== 4'(s)) begin
        bad++;
        $display("FAIL wrong_done: state=%0d want %0d", state, s);
      end
    end
    drive_done(s, 1);
    if (s < 11) sb.push_back(model(s + 1));
    step();
    drive_done(s, 0);
  endtask

  task automatic check_frame_end();
    @(negedge clk);
    total++;
    if (state !== 4'd0 || frame_done !== 1'b1 || {fmap_size, cin, cout, wbase} !== 30'd0) begin
      bad++;
      $display("FAIL frame_end: state=%0d frame_done=%b cfg=%0d/%0d/%0d/%0d want 0/1/zero", state, frame_done, fmap_size, cin, cout, wbase);
    end
  endtask

  task automatic run_frame(input bit wrong);
    load();
    for (int s = 1; s <= 11; s++) run_layer(s, wrong);
    check_frame_end();
    step();
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL frame_done_width: frame_done=%b want 0", frame_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (state !== 4'd0 || busy !== 0 || frame_done !== 0 || timeout_err !== 0 ||
        {conv_start, avg_start, fc_start, judge_start, fmap_size, cin, cout, wbase} !== 34'd0) begin
      bad++;
      $display("FAIL reset_state: state=%0d busy=%b fd=%b te=%b want all zero", state, busy, frame_done, timeout_err);
    end
    step();
    reset = 1;
    step();
  endtask

  task automatic test_nominal();
    run_frame(0);
  endtask

  task automatic test_wrong_done();
    run_frame(1);
  endtask

  task automatic test_back_to_back();
    load();
    for (int s = 1; s <= 11; s++) run_layer(s, 0);
    check_frame_end();
    address = 13'd6399;
    step();
    address = 13'd1;
    sb.push_back(model(1));
    step();
    for (int s = 1; s <= 11; s++) run_layer(s, 0);
    check_frame_end();
    step();
  endtask

  task automatic test_timeout();
    load();
    for (int s = 1; s <= 3; s++) run_layer(s, 0);
    repeat (15) step();
    @(negedge clk);
    total++;
    if (state !== 4'd4 || timeout_err !== 0) begin
      bad++;
      $display("FAIL timeout_early: state=%0d te=%b want 4/0", state, timeout_err);
    end
    step();
    @(negedge clk);
    total++;
    if (state !== 4'd0 || timeout_err !== 1 || frame_done !== 0) begin
      bad++;
      $display("FAIL timeout_fire: state=%0d te=%b fd=%b want 0/1/0", state, timeout_err, frame_done);
    end
    repeat (3) step();
    run_frame(0);
    total++;
    if (timeout_err !== 1) begin
      bad++;
      $display("FAIL timeout_sticky: te=%b want 1", timeout_err);
    end
  endtask

  task automatic test_abort();
    load();
    for (int s = 1; s <= 5; s++) run_layer(s, 0);
    step();
    step();
    avg_done = 1;
    abort = 1;
    step();
    avg_done = 0;
    abort = 0;
    @(negedge clk);
    total++;
    if (state !== 4'd0 || frame_done !== 0) begin
      bad++;
      $display("FAIL abort_win: state=%0d fd=%b want 0/0", state, frame_done);
    end
    repeat (3) step();
    address = 13'd6399;
    step();
    address = 13'd1;
    abort = 1;
    step();
    abort = 0;
    repeat (3) step();
    @(negedge clk);
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL abort_idle_disarm: state=%0d want 0", state);
    end
  endtask

  task automatic test_no_load();
    bit seen = 0;
    for (int a = 0; a <= 6398; a++) begin
      address = 13'(a);
      step();
      if (busy !== 0 || state !== 4'd0) seen = 1;
    end
    address = 13'd0;
    repeat (3) step();
    total++;
    if (seen || busy !== 0 || state !== 4'd0) begin
      bad++;
      $display("FAIL no_load: state=%0d busy=%b seen=%b want idle", state, busy, seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    load();
    for (int s = 1; s <= 7; s++) run_layer(s, 0);
    step();
    #2;
    reset = 0;
    #1;
    total++;
    if (state !== 4'd0 || busy !== 0 || timeout_err !== 0 || frame_done !== 0 ||
        {conv_start, avg_start, fc_start, judge_start, fmap_size, cin, cout, wbase} !== 34'd0) begin
      bad++;
      $display("FAIL reset_async: state=%0d busy=%b te=%b cfg=%0d/%0d/%0d/%0d want zero", state, busy, timeout_err, fmap_size, cin, cout, wbase);
    end
    step();
    reset = 1;
    step();
    for (int s = 1; s <= 11; s++) begin
      drive_done(s, 1);
      step();
      drive_done(s, 0);
    end
    step();
    @(negedge clk);
    total++;
    if (state !== 4'd0 || busy !== 0) begin
      bad++;
      $display("FAIL reset_no_restart: state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrong_done();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_no_load();
    test_reset_mid_frame();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_start: %0d expected layer entries never seen, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
